gate_resp_checker: RTL and testbench

Hardware response checker: the receiving end of the gate stimulus/monitor flow. It accepts one observed vector per handshake: inputs A/B plus the AND/OR/NOT/XOR outputs of the gate set under test. Each vector is compared against a golden model, and per-run pass/fail status, error counts and a sticky per-gate failure mask are accumulated. It sits beside the gate library as an on-chip self-check, fed by a stimulus driver or a capture register.

---
 rtl/gate_chk_pkg.sv | 21 ++
 rtl/gate_golden.sv | 22 ++
 rtl/gate_resp_checker.sv | 150 +++++++++++++++
 tb/tb_gate_resp_checker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg
// Shared definitions for the gate response checker:
//   state_t   - checker FSM states (IDLE, RUN, DONE)
//   GATE_*    - bit positions of each gate inside a packed 4-bit result vector
//   MASK_W    - width of the packed gate vector and of the fail/coverage masks
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GATE_AND = 0;
    localparam int GATE_OR  = 1;
    localparam int GATE_NOT = 2;
    localparam int GATE_XOR = 3;

    localparam int MASK_W = 4;

endpackage

// File: rtl/gate_golden.sv
// gate_golden
// Purely combinational reference model of the gate set under test.
// Ports:
//   a, b      - stimulus inputs
//   expected  - golden results packed {xor, not, or, and} using the GATE_* indices
module gate_golden
    import gate_chk_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [MASK_W-1:0] expected
);

    always_comb begin
        expected           = '0;
        expected[GATE_AND] = a & b;
        expected[GATE_OR]  = a | b;
        expected[GATE_NOT] = ~a;
        expected[GATE_XOR] = a ^ b;
    end

endmodule

// File: rtl/gate_resp_checker.sv
// gate_resp_checker
// Accepts one observed gate vector per valid/ready handshake, compares it with
// the golden model and accumulates per-run status.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   start               - one-cycle run request (honoured in IDLE and DONE)
//   in_valid / in_ready - observed-vector handshake
//   in_a, in_b          - stimulus applied to the gates
//   in_and .. in_xor    - observed gate outputs
//   busy, done, pass    - run status; pass is meaningful only while done=1
//   err_count           - mismatching vectors this run (saturating)
//   vec_count           - accepted vectors this run (saturating)
//   fail_mask           - sticky per-gate mismatch flags {xor,not,or,and}
//   cov_mask            - sticky {A,B} coverage, bit index = {A,B}
// Optional feature macro: GATE_CHK_COVER_EN
//   defined   - cov_mask is tracked and pass also requires full coverage
//   undefined - cov_mask is tied to 0 and pass only requires zero errors
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int VEC_COUNT = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_a,
    input  logic              in_b,
    input  logic              in_and,
    input  logic              in_or,
    input  logic              in_not,
    input  logic              in_xor,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  vec_count,
    output logic [MASK_W-1:0] fail_mask,
    output logic [MASK_W-1:0] cov_mask
);

    // The run length is tracked separately from vec_count because vec_count
    // may saturate before VEC_COUNT accepts have been seen.
    localparam int ACC_W = $clog2(VEC_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc_count;
    logic [MASK_W-1:0]  expected;
    logic [MASK_W-1:0]  observed;
    logic [MASK_W-1:0]  mismatch;
    logic               accept;
    logic               last_accept;
    logic               clear;
    logic               pass_calc;

    gate_golden u_golden (
        .a        (in_a),
        .b        (in_b),
        .expected (expected)
    );

    always_comb begin
        observed           = '0;
        observed[GATE_AND] = in_and;
        observed[GATE_OR]  = in_or;
        observed[GATE_NOT] = in_not;
        observed[GATE_XOR] = in_xor;
    end

    assign mismatch    = expected ^ observed;
    assign accept      = in_valid && in_ready;
    assign last_accept = (acc_count == ACC_W'(VEC_COUNT - 1));
    assign clear       = start && ((state == IDLE) || (state == DONE));

`ifdef GATE_CHK_COVER_EN
    logic [MASK_W-1:0] cov_reg;
    logic [MASK_W-1:0] cov_hit;

    assign cov_hit   = MASK_W'(1) << {in_a, in_b};
    assign cov_mask  = cov_reg;
    // Evaluated on the final accept, so it must include that vector's effect.
    assign pass_calc = (err_count == '0) && !(|mismatch) &&
                       ((cov_reg | cov_hit) == {MASK_W{1'b1}});
`else
    assign cov_mask  = '0;
    assign pass_calc = (err_count == '0) && !(|mismatch);
`endif

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last_accept) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_count <= '0;
            err_count <= '0;
            vec_count <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
`ifdef GATE_CHK_COVER_EN
            cov_reg   <= '0;
`endif
        end else begin
            state <= state_next;
            if (clear) begin
                acc_count <= '0;
                err_count <= '0;
                vec_count <= '0;
                fail_mask <= '0;
                pass      <= 1'b0;
`ifdef GATE_CHK_COVER_EN
                cov_reg   <= '0;
`endif
            end else if (accept) begin
                acc_count <= acc_count + 1'b1;
                if (vec_count != CNT_MAX) vec_count <= vec_count + 1'b1;
                if ((|mismatch) && (err_count != CNT_MAX)) err_count <= err_count + 1'b1;
                fail_mask <= fail_mask | mismatch;
                if (last_accept) pass <= pass_calc;
`ifdef GATE_CHK_COVER_EN
                cov_reg   <= cov_reg | cov_hit;
`endif
            end
        end
    end

endmodule

// File: tb/tb_gate_resp_checker.sv
// tb_gate_resp_checker
// Directed bench for gate_resp_checker. Instance dut uses default parameters;
// instance dut_sat uses CNT_W=2, VEC_COUNT=6 to exercise counter saturation.
// Expected coverage/pass values follow GATE_CHK_COVER_EN when it is defined.
module tb_gate_resp_checker;

`ifdef GATE_CHK_COVER_EN
    localparam bit COVER = 1'b1;
`else
    localparam bit COVER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 0, in_valid = 0, in_a = 0, in_b = 0;
    logic       in_and = 0, in_or = 0, in_not = 0, in_xor = 0;
    logic       in_ready, busy, done, pass;
    logic [7:0] err_count, vec_count;
    logic [3:0] fail_mask, cov_mask;

    logic       s_start = 0, s_valid = 0, s_a = 0, s_b = 0;
    logic       s_and = 0, s_or = 0, s_not = 0, s_xor = 0;
    logic       s_ready, s_busy, s_done, s_pass;
    logic [1:0] s_err, s_vec;
    logic [3:0] s_fail, s_cov;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_resp_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_and(in_and), .in_or(in_or), .in_not(in_not),
        .in_xor(in_xor), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .vec_count(vec_count), .fail_mask(fail_mask), .cov_mask(cov_mask)
    );

    gate_resp_checker #(.VEC_COUNT(6), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
        .in_a(s_a), .in_b(s_b), .in_and(s_and), .in_or(s_or), .in_not(s_not),
        .in_xor(s_xor), .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .vec_count(s_vec), .fail_mask(s_fail), .cov_mask(s_cov)
    );

    // Advance one clock and settle just past the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a vector on dut; flip = {xor,not,or,and} bits to corrupt.
    task automatic drive_vec(input logic a, input logic b, input logic [3:0] flip);
        in_a   = a;
        in_b   = b;
        in_and = (a & b) ^ flip[0];
        in_or  = (a | b) ^ flip[1];
        in_not = (~a)    ^ flip[2];
        in_xor = (a ^ b) ^ flip[3];
    endtask

    task automatic drive_sat(input logic a, input logic b, input logic [3:0] flip);
        s_a   = a;
        s_b   = b;
        s_and = (a & b) ^ flip[0];
        s_or  = (a | b) ^ flip[1];
        s_not = (~a)    ^ flip[2];
        s_xor = (a ^ b) ^ flip[3];
    endtask

    // Pulse start on dut and confirm the run began with cleared counters.
    task automatic begin_run();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_start: busy/ready/done got %b%b%b expected 110", busy, in_ready, done);
        end
        checks++;
        if (vec_count !== 8'd0 || err_count !== 8'd0 || fail_mask !== 4'd0 || cov_mask !== 4'd0) begin
            errors++;
            $display("[TB] FAIL run_clear: vec %0d err %0d fail %b cov %b expected all 0",
                     vec_count, err_count, fail_mask, cov_mask);
        end
    endtask

    // Four back-to-back vectors {A,B} = 0..3, with vector bad_idx corrupted by flip.
    task automatic run_four(input int bad_idx, input logic [3:0] flip, input logic all_zero);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = all_zero ? 2'b00 : 2'(i);
            drive_vec(ab[1], ab[0], (i == bad_idx) ? flip : 4'b0000);
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ready_%0d: got %b expected 1", i, in_ready);
            end
            step();
            checks++;
            if (vec_count !== 8'(i + 1) || done !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL accept_%0d: vec %0d done %b expected vec %0d done %b",
                         i, vec_count, done, i + 1, (i == 3));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({in_ready, busy, done, pass} !== 4'b0000 || err_count !== 8'd0 || vec_count !== 8'd0 ||
            fail_mask !== 4'd0 || cov_mask !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready/busy/done/pass %b%b%b%b err %0d vec %0d fail %b cov %b expected all 0",
                     in_ready, busy, done, pass, err_count, vec_count, fail_mask, cov_mask);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_clean_run();
        begin_run();
        run_four(-1, 4'b0000, 1'b0);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || err_count !== 8'd0 || fail_mask !== 4'd0 ||
            pass !== 1'b1 || cov_mask !== (COVER ? 4'b1111 : 4'b0000)) begin
            errors++;
            $display("[TB] FAIL clean_done: busy %b ready %b err %0d fail %b pass %b cov %b expected 0 0 0 0000 1 %b",
                     busy, in_ready, err_count, fail_mask, pass, cov_mask, COVER ? 4'b1111 : 4'b0000);
        end
    endtask

    task automatic test_mismatch();
        begin_run();
        run_four(2, 4'b1001, 1'b0);
        checks++;
        if (err_count !== 8'd1 || fail_mask !== 4'b1001 || pass !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mismatch_done: err %0d fail %b pass %b expected 1 1001 0",
                     err_count, fail_mask, pass);
        end
    endtask

    task automatic test_coverage();
        begin_run();
        run_four(-1, 4'b0000, 1'b1);
        checks++;
        if (err_count !== 8'd0 || cov_mask !== (COVER ? 4'b0001 : 4'b0000) || pass !== !COVER) begin
            errors++;
            $display("[TB] FAIL coverage_done: err %0d cov %b pass %b expected 0 %b %b",
                     err_count, cov_mask, pass, COVER ? 4'b0001 : 4'b0000, !COVER);
        end
    endtask

    task automatic test_gapped();
        logic [6:0] valid_pat;
        logic [6:0] start_pat;
        int         accepts;
        valid_pat = 7'b1011001;
        start_pat = 7'b0010100;
        accepts   = 0;
        begin_run();
        for (int c = 0; c < 7; c++) begin
            in_valid = valid_pat[c];
            start    = start_pat[c];
            if (valid_pat[c]) drive_vec(accepts[1], accepts[0], 4'b0000);
            else              drive_vec(1'b1, 1'b1, 4'b1111);
            step();
            if (valid_pat[c]) accepts++;
            checks++;
            if (vec_count !== 8'(accepts) || err_count !== 8'd0 || done !== (c == 6)) begin
                errors++;
                $display("[TB] FAIL gapped_%0d: vec %0d err %0d done %b expected %0d 0 %b",
                         c, vec_count, err_count, done, accepts, (c == 6));
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        begin_run();
        for (int i = 0; i < 2; i++) begin
            drive_vec(i[1], i[0], 4'b0000);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, done, pass} !== 4'b0000 || vec_count !== 8'd0 || err_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: ready/busy/done/pass %b%b%b%b vec %0d err %0d expected all 0",
                     in_ready, busy, done, pass, vec_count, err_count);
        end
        step();
        rst_n = 1'b1;
        drive_vec(1'b0, 1'b0, 4'b0000);
        in_valid = 1'b1;
        step();
        checks++;
        if (vec_count !== 8'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_valid: vec %0d ready %b expected 0 0", vec_count, in_ready);
        end
        begin_run();
        step();
        in_valid = 1'b0;
        checks++;
        if (vec_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL fresh_run: vec %0d expected 1", vec_count);
        end
    endtask

    task automatic test_saturation();
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_sat(i[1], i[0], 4'b1111);
            s_valid = 1'b1;
            step();
            checks++;
            if (s_vec !== 2'((i + 1 > 3) ? 3 : i + 1) || s_err !== 2'((i + 1 > 3) ? 3 : i + 1) ||
                s_done !== (i == 5)) begin
                errors++;
                $display("[TB] FAIL sat_%0d: vec %0d err %0d done %b expected %0d %0d %b",
                         i, s_vec, s_err, s_done, (i + 1 > 3) ? 3 : i + 1, (i + 1 > 3) ? 3 : i + 1, (i == 5));
            end
        end
        s_valid = 1'b0;
        checks++;
        if (s_pass !== 1'b0 || s_fail !== 4'b1111 || s_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_done: pass %b fail %b busy %b expected 0 1111 0", s_pass, s_fail, s_busy);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_mismatch();
        test_coverage();
        test_gapped();
        test_reset_mid_run();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
